mod_reduce_divider: RTL and testbench

- Sequential radix-2 restoring divider. It is the inverse stage to the Karatsuba/Booth multiplier `non_standard_dsp`.
- Takes the 2*LOGQ-bit product and a LOGQ-bit modulus q. Returns quotient and remainder (c mod q).
- Sits directly downstream of the multiplier in the modular-arithmetic datapath.
- Uses a valid/ready handshake on both sides and processes one quotient bit per clock.

---
 rtl/modarith_pkg.sv | 25 ++
 rtl/mod_reduce_divider_div_step.sv | 34 +++
 rtl/mod_reduce_divider.sv | 122 ++++++++++++
 tb/tb_mod_reduce_divider.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modarith_pkg.sv
// ----------------------------------------------------------------------------
// modarith_pkg
// Shared definitions for the modular-arithmetic datapath:
//   LOGQ_DEF  - default modulus width in bits
//   state_t   - divider FSM states (IDLE / CALC / DONE)
//   cnt_width - width of an iteration counter able to hold 2*logq
//   CNT_W     - counter width for the default modulus width
// ----------------------------------------------------------------------------
package modarith_pkg;

  localparam int unsigned LOGQ_DEF = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned logq);
    return $clog2(2 * logq + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_width(LOGQ_DEF);

endpackage

// File: rtl/mod_reduce_divider_div_step.sv
// ----------------------------------------------------------------------------
// div_step
// One combinational radix-2 restoring division iteration.
//   i_rem  [LOGQ:0]   partial remainder from the previous iteration (< divisor)
//   i_bit             next dividend bit (MSB first)
//   i_div  [LOGQ-1:0] divisor
//   o_rem  [LOGQ:0]   new partial remainder
//   o_qbit            quotient bit produced by this iteration
// ----------------------------------------------------------------------------
module div_step
  import modarith_pkg::*;
#(
  parameter int unsigned LOGQ = LOGQ_DEF
) (
  input  logic [LOGQ:0]   i_rem,
  input  logic            i_bit,
  input  logic [LOGQ-1:0] i_div,
  output logic [LOGQ:0]   o_rem,
  output logic            o_qbit
);

  // One guard bit above the shifted remainder so the trial difference's
  // MSB is a reliable sign bit.
  logic [LOGQ+1:0] w_shift;
  logic [LOGQ+1:0] w_diff;

  always_comb begin
    w_shift = {i_rem, i_bit};
    w_diff  = w_shift - {2'b00, i_div};
    o_qbit  = ~w_diff[LOGQ+1];
    o_rem   = o_qbit ? w_diff[LOGQ:0] : w_shift[LOGQ:0];
  end

endmodule

// File: rtl/mod_reduce_divider.sv
// ----------------------------------------------------------------------------
// mod_reduce_divider
// Sequential restoring divider: out_quo = floor(in_c / in_q),
// out_rem = in_c mod in_q, one quotient bit per clock.
//   clk, rst             clock; synchronous active-low reset
//   in_valid / in_ready  operand handshake (in_c: 2*LOGQ bits, in_q: LOGQ bits)
//   out_valid / out_ready result handshake
//   out_quo  [2*LOGQ-1:0] quotient (all ones on divide-by-zero)
//   out_rem  [LOGQ-1:0]   remainder (low LOGQ bits of in_c on divide-by-zero)
//   out_dz               divide-by-zero flag for the current result
// ----------------------------------------------------------------------------
module mod_reduce_divider
  import modarith_pkg::*;
#(
  parameter int unsigned LOGQ = LOGQ_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*LOGQ-1:0] in_c,
  input  logic [LOGQ-1:0]   in_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*LOGQ-1:0] out_quo,
  output logic [LOGQ-1:0]   out_rem,
  output logic              out_dz
);

  localparam int unsigned CW = cnt_width(LOGQ);

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB,
  // so one register holds both; after 2*LOGQ shifts it is the quotient.
  logic [2*LOGQ-1:0]   r_dq;
  logic [LOGQ-1:0]     r_div;
  logic [LOGQ:0]       r_prem;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [2*LOGQ-1:0]   r_quo;
  logic [LOGQ-1:0]     r_rem;
  logic                r_dz;

  logic [LOGQ:0]       w_prem_next;
  logic                w_qbit;

  div_step #(.LOGQ(LOGQ)) u_step (
    .i_rem  (r_prem),
    .i_bit  (r_dq[2*LOGQ-1]),
    .i_div  (r_div),
    .o_rem  (w_prem_next),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_dq        <= '0;
      r_div       <= '0;
      r_prem      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_dz        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_dq       <= in_c;
            r_div      <= in_q;
            r_prem     <= '0;
            r_in_ready <= 1'b0;
            if (in_q != '0) begin
              r_cnt   <= CW'(2 * LOGQ);
              r_state <= S_CALC;
            end else begin
              r_quo       <= '1;
              r_rem       <= in_c[LOGQ-1:0];
              r_dz        <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_CALC: begin
          r_dq   <= {r_dq[2*LOGQ-2:0], w_qbit};
          r_prem <= w_prem_next;
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_quo       <= {r_dq[2*LOGQ-2:0], w_qbit};
            r_rem       <= w_prem_next[LOGQ-1:0];
            r_dz        <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_quo   = r_quo;
  assign out_rem   = r_rem;
  assign out_dz    = r_dz;

endmodule

// File: tb/tb_mod_reduce_divider.sv
// ----------------------------------------------------------------------------
// tb_mod_reduce_divider
// Self-checking bench for mod_reduce_divider at LOGQ=64.
// ----------------------------------------------------------------------------
module tb_mod_reduce_divider;

  localparam int unsigned L = 64;
  localparam int unsigned W = 2 * L;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_c;
  logic [L-1:0] in_q;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_quo;
  logic [L-1:0] out_rem;
  logic         out_dz;

  int errors = 0;
  int checks = 0;

  mod_reduce_divider #(.LOGQ(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_c      (in_c),
    .in_q      (in_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_quo   (out_quo),
    .out_rem   (out_rem),
    .out_dz    (out_dz)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  // Reference: plain integer division, with the divide-by-zero convention.
  task automatic model(input logic [W-1:0] c, input logic [L-1:0] q,
                       output logic [W-1:0] eq, output logic [L-1:0] er,
                       output logic edz);
    if (q == '0) begin
      eq  = '1;
      er  = c[L-1:0];
      edz = 1'b1;
    end else begin
      eq  = c / {{L{1'b0}}, q};
      er  = L'(c % {{L{1'b0}}, q});
      edz = 1'b0;
    end
  endtask

  // Waits (bounded) for in_ready, presents one operand pair for one edge,
  // then counts edges until out_valid (0 means valid right after accept).
  task automatic start_op(input logic [W-1:0] c, input logic [L-1:0] q,
                          output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 400) begin
      @(posedge clk); #1;
      w++;
    end
    in_c     = c;
    in_q     = q;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_c      = '0;
    in_q      = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_quo !== '0 ||
        out_rem !== '0 || out_dz !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b quo=%h rem=%h dz=%b expected 1 0 0 0 0",
               in_ready, out_valid, out_quo, out_rem, out_dz);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] tc [5];
    logic [L-1:0] tq [5];
    logic [W-1:0] xq [5];
    logic [L-1:0] xr [5];
    int lat;
    tc[0] = 128'd9;        tq[0] = 64'd3;    xq[0] = 128'd3;     xr[0] = 64'd0;
    tc[1] = 128'd5000;     tq[1] = 64'd7;    xq[1] = 128'd714;   xr[1] = 64'd2;
    tc[2] = 128'd16777216; tq[2] = 64'd1000; xq[2] = 128'd16777; xr[2] = 64'd216;
    tc[3] = '1;            tq[3] = '1;       xq[3] = 128'h1_0000_0000_0000_0001; xr[3] = 64'd0;
    tc[4] = '1;            tq[4] = 64'd1;    xq[4] = '1;         xr[4] = 64'd0;
    for (int i = 0; i < 5; i++) begin
      start_op(tc[i], tq[i], lat);
      checks++;
      if (lat !== 128) begin
        errors++;
        $display("FAIL directed%0d_latency: got %0d expected 128", i, lat);
      end
      checks++;
      if (out_quo !== xq[i] || out_rem !== xr[i] || out_dz !== 1'b0) begin
        errors++;
        $display("FAIL directed%0d_result: got quo=%h rem=%h dz=%b expected quo=%h rem=%h dz=0",
                 i, out_quo, out_rem, out_dz, xq[i], xr[i]);
      end
      handshake();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL directed%0d_release: got vld=%b rdy=%b expected 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_divzero();
    int lat;
    start_op(128'h1234_0000_0000_0000_0000_0000_ABCD, 64'd0, lat);
    checks++;
    if (lat !== 0) begin
      errors++;
      $display("FAIL divzero_latency: got %0d expected 0", lat);
    end
    checks++;
    if (out_dz !== 1'b1 || out_quo !== {W{1'b1}} || out_rem !== 64'h0000_0000_0000_ABCD) begin
      errors++;
      $display("FAIL divzero_result: got quo=%h rem=%h dz=%b expected all-ones 000000000000abcd 1",
               out_quo, out_rem, out_dz);
    end
    handshake();
    // Result registers keep the last value after the handshake.
    checks++;
    if (out_valid !== 1'b0 || out_dz !== 1'b1 || out_rem !== 64'hABCD) begin
      errors++;
      $display("FAIL divzero_retain: got vld=%b dz=%b rem=%h expected 0 1 abcd",
               out_valid, out_dz, out_rem);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    start_op(128'd5000, 64'd7, lat);
    checks++;
    if (lat !== 128 || out_quo !== 128'd714 || out_rem !== 64'd2) begin
      errors++;
      $display("FAIL bp_first: got lat=%0d quo=%0d rem=%0d expected 128 714 2", lat, out_quo, out_rem);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_c = {$urandom, $urandom, $urandom, $urandom};
      in_q = 64'd3;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_quo !== 128'd714 ||
          out_rem !== 64'd2 || out_dz !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got vld=%b rdy=%b quo=%0d rem=%0d dz=%b expected 1 0 714 2 0",
                 i, out_valid, in_ready, out_quo, out_rem, out_dz);
      end
    end
    in_c = 128'd100;
    in_q = 64'd9;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: got rdy=%b expected 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 128 || out_quo !== 128'd11 || out_rem !== 64'd1 || out_dz !== 1'b0) begin
      errors++;
      $display("FAIL bp_second: got lat=%0d quo=%0d rem=%0d dz=%b expected 128 11 1 0",
               lat, out_quo, out_rem, out_dz);
    end
    handshake();
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    in_c     = {$urandom, $urandom, $urandom, $urandom};
    in_q     = 64'd12345;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_quo !== '0 || out_dz !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: got rdy=%b vld=%b quo=%h dz=%b expected 1 0 0 0",
               in_ready, out_valid, out_quo, out_dz);
    end
    rst = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL midreset_quiet%0d: got vld=%b rdy=%b expected 0 1", i, out_valid, in_ready);
      end
    end
    start_op(128'd9, 64'd3, lat);
    checks++;
    if (lat !== 128 || out_quo !== 128'd3 || out_rem !== 64'd0 || out_dz !== 1'b0) begin
      errors++;
      $display("FAIL midreset_after: got lat=%0d quo=%0d rem=%0d dz=%b expected 128 3 0 0",
               lat, out_quo, out_rem, out_dz);
    end
    handshake();
  endtask

  task automatic test_random();
    logic [W-1:0] c, eq;
    logic [L-1:0] q, er;
    logic edz;
    int unsigned wq;
    int lat, elat;
    for (int i = 0; i < 24; i++) begin
      c  = {$urandom, $urandom, $urandom, $urandom};
      c  = c >> $urandom_range(0, 127);
      wq = $urandom_range(0, 64);
      q  = (wq == 0) ? '0 : ({$urandom, $urandom} >> (64 - wq));
      model(c, q, eq, er, edz);
      elat = edz ? 0 : 128;
      start_op(c, q, lat);
      checks++;
      if (lat !== elat || out_quo !== eq || out_rem !== er || out_dz !== edz) begin
        errors++;
        $display("FAIL random%0d c=%h q=%h: got lat=%0d quo=%h rem=%h dz=%b expected %0d %h %h %b",
                 i, c, q, lat, out_quo, out_rem, out_dz, elat, eq, er, edz);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      handshake();
    end
  endtask

  task automatic test_back_to_back();
    int stamp [3];
    int seen, cyc;
    seen = 0;
    cyc  = 0;
    out_ready = 1'b1;
    in_c      = 128'd5000;
    in_q      = 64'd7;
    in_valid  = 1'b1;
    while (seen < 3 && cyc < 600) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid) begin
        stamp[seen] = cyc;
        seen++;
        checks++;
        if (out_quo !== 128'd714 || out_rem !== 64'd2) begin
          errors++;
          $display("FAIL b2b_result%0d: got quo=%0d rem=%0d expected 714 2", seen, out_quo, out_rem);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (seen !== 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d results expected 3", seen);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (stamp[i] - stamp[i-1] !== 130) begin
          errors++;
          $display("FAIL b2b_period%0d: got %0d cycles expected 130", i, stamp[i] - stamp[i-1]);
        end
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_divzero();
    test_backpressure();
    test_reset_mid_calc();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
